// File: rtl/vexp_lane_seq.sv
// Lane sequencer: feeds bf16 vector lanes one at a time to a shared exp unit.
// Optional VEXP_SEQ_ZERO_BYPASS_EN: +/-0 lanes resolve to 1.0 without an issue.
module vexp_lane_seq #(
    parameter int LANES = 4,
    parameter int OP_W  = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*16-1:0]   in_data,
    input  logic [OP_W-1:0]       in_op,
    output logic                  exp_valid_in,
    output logic [OP_W-1:0]       exp_operand,
    output logic [15:0]           exp_a,
    input  logic                  exp_done,
    input  logic [15:0]           exp_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*16-1:0]   out_data,
    output logic                  busy
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [LANES*16-1:0]   data_q;
    logic [LANES*16-1:0]   res_q;
    logic [OP_W-1:0]       op_q;
    logic [15:0]           cur_lane;

    always_comb begin
        cur_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idx_q == IDX_W'(i)) cur_lane = data_q[16*i +: 16];
        end
    end

    function automatic logic [LANES*16-1:0] put_lane(
        input logic [LANES*16-1:0] vec,
        input logic [IDX_W-1:0]    idx,
        input logic [15:0]         val
    );
        logic [LANES*16-1:0] v;
        v = vec;
        for (int i = 0; i < LANES; i++) begin
            if (idx == IDX_W'(i)) v[16*i +: 16] = val;
        end
        return v;
    endfunction

`ifdef VEXP_SEQ_ZERO_BYPASS_EN
    logic lane_zero;
    assign lane_zero    = (cur_lane[14:0] == 15'd0);
    assign exp_valid_in = (state_q == ISSUE) && !lane_zero;
`else
    assign exp_valid_in = (state_q == ISSUE);
`endif

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_data    = res_q;
    assign exp_a       = cur_lane;
    assign exp_operand = op_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        op_q    <= in_op;
                        idx_q   <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef VEXP_SEQ_ZERO_BYPASS_EN
                    if (lane_zero) begin
                        res_q <= put_lane(res_q, idx_q, 16'h3F80);
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        state_q <= WAIT;
                    end
`else
                    state_q <= WAIT;
`endif
                end
                WAIT: begin
                    // only one op is in flight, so the done pulse belongs to idx_q
                    if (exp_done) begin
                        res_q <= put_lane(res_q, idx_q, exp_result);
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vexp_lane_seq.sv
// Random-stimulus bench for vexp_lane_seq against a vector-level model
// with a fixed 3-cycle exp unit.
module tb_vexp_lane_seq;

    logic        CLK;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_op;
    logic        exp_valid_in;
    logic [1:0]  exp_operand;
    logic [15:0] exp_a;
    logic        exp_done;
    logic [15:0] exp_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    logic        in_valid1, in_ready1, exp_valid_in1, exp_done1;
    logic        out_valid1, out_ready1, busy1;
    logic [15:0] in_data1, exp_a1, exp_result1, out_data1, r1;
    logic [1:0]  in_op1, exp_operand1;
    logic        md1;

    logic        md, sd;
    logic [15:0] mres, ha;
    logic [1:0]  hop;
    int          cnt;
    int          issues;
    bit          abandoned;
    time         last_done_t;

    int n_chk;
    int n_fail;

    assign exp_done    = md | sd;
    assign exp_result  = md ? mres : 16'hDEAD;
    assign exp_done1   = md1;
    assign exp_result1 = md1 ? r1 : 16'hDEAD;

    vexp_lane_seq #(.LANES(4), .OP_W(2)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op),
        .exp_valid_in(exp_valid_in), .exp_operand(exp_operand),
        .exp_a(exp_a), .exp_done(exp_done), .exp_result(exp_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    vexp_lane_seq #(.LANES(1), .OP_W(2)) u_dut1 (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_op(in_op1),
        .exp_valid_in(exp_valid_in1), .exp_operand(exp_operand1),
        .exp_a(exp_a1), .exp_done(exp_done1), .exp_result(exp_result1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .busy(busy1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fexp(input logic [15:0] a,
                                         input logic [1:0] op);
        return a + 16'h00AE + 16'(op) * 16'h0101;
    endfunction

    // expected result vector, number of exp-unit issues, last lane issued
    function automatic logic [63:0] ref_vec(input logic [63:0] d,
                                            input logic [1:0] op,
                                            output int n, output bit last_iss);
        logic [63:0] e;
        logic [15:0] l;
        bit          z;
        e = '0;
        n = 0;
        last_iss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            l = d[16*i +: 16];
`ifdef VEXP_SEQ_ZERO_BYPASS_EN
            z = (l[14:0] == 15'd0);
`else
            z = 1'b0;
`endif
            e[16*i +: 16] = z ? 16'h3F80 : fexp(l, op);
            if (!z) n++;
            last_iss = !z;
        end
        return e;
    endfunction

    // exp unit: result 3 cycles after the issue strobe, one cycle wide
    always @(negedge CLK) begin
        if (md) md = 1'b0;
        if (cnt != 0) begin
            cnt--;
            if (cnt == 0) begin
                md = 1'b1;
                mres = fexp(ha, hop);
                last_done_t = $time;
                if (!abandoned) begin
                    chk("exp_a_hold", 64'(exp_a), 64'(ha));
                    chk("exp_op_hold", 64'(exp_operand), 64'(hop));
                end
            end
        end
        if (exp_valid_in) begin
            chk("single_outstanding", 64'(cnt), 64'd0);
            ha = exp_a;
            hop = exp_operand;
            cnt = 3;
            issues++;
        end
    end

    task automatic run_vec(input logic [63:0] d, input logic [1:0] op,
                           input int stall, input bit spur);
        int          n_exp;
        bit          last_iss;
        bit          got;
        logic [63:0] e;
        e = ref_vec(d, op, n_exp, last_iss);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("in_ready_idle", 64'(got), 64'd1);
        issues = 0;
        in_valid = 1'b1;
        in_data = d;
        in_op = op;
        @(negedge CLK);
        in_valid = 1'b0;
        in_data = {$urandom, $urandom};
        in_op = ~op;
        chk("busy_after_accept", 64'(busy), 64'd1);
        if (spur) begin
            sd = 1'b1;
            @(negedge CLK);
            sd = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("out_valid_timeout", 64'(got), 64'd1);
        if (got) begin
            if (last_iss)
                chk("out_valid_latency", 64'($time - last_done_t), 64'd10);
            chk("issue_count", 64'(issues), 64'(n_exp));
            chk("out_data", out_data, e);
            for (int i = 0; i < stall; i++) begin
                @(negedge CLK);
                chk("stall_data", out_data, e);
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_busy", 64'(busy), 64'd1);
            end
            out_ready = 1'b1;
            chk("hs_in_ready", 64'(in_ready), 64'd0);
            @(negedge CLK);
            out_ready = 1'b0;
            chk("post_hs_valid", 64'(out_valid), 64'd0);
            chk("post_hs_busy", 64'(busy), 64'd0);
            chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [15:0] av [2];
        logic [1:0]  opv [2];
        bit          got;

        n_chk = 0;
        n_fail = 0;
        md = 1'b0; sd = 1'b0; mres = '0; ha = '0; hop = '0;
        cnt = 0; issues = 0; abandoned = 1'b0; last_done_t = 0;
        in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; in_op1 = '0; out_ready1 = 1'b0;
        md1 = 1'b0; r1 = '0;
        nRST = 1'b1;
        #2 nRST = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_exp_valid", 64'(exp_valid_in), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_exp_a", 64'(exp_a), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #19 nRST = 1'b1;
        @(negedge CLK);

        // stray done while idle
        sd = 1'b1;
        @(negedge CLK);
        sd = 1'b0;
        @(negedge CLK);
        chk("spur_idle_busy", 64'(busy), 64'd0);
        chk("spur_idle_data", out_data, 64'd0);

        run_vec({4{16'h3F80}}, 2'd0, 0, 1'b0);
        run_vec({16'h1111, 16'h2222, 16'h3333, 16'h4444}, 2'd1, 10, 1'b1);
        run_vec({16'h3F80, 16'h8000, 16'h3F80, 16'h0000}, 2'd2, 1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            d = {$urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0)
                    d[16*i +: 16] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
            end
            run_vec(d, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        // abandon a vector while lane 2 is outstanding
        issues = 0;
        in_valid = 1'b1;
        in_data = {$urandom, $urandom} | 64'h4000_4000_4000_4000;
        in_op = 2'd3;
        @(negedge CLK);
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (issues >= 3) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("lane2_reached", 64'(got), 64'd1);
        @(negedge CLK);
        abandoned = 1'b1;
        nRST = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_exp_valid", 64'(exp_valid_in), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_exp_a", 64'(exp_a), 64'd0);
        chk("mid_rst_exp_op", 64'(exp_operand), 64'd0);
        #1 nRST = 1'b1;
        repeat (4) @(negedge CLK);
        abandoned = 1'b0;
        chk("late_done_busy", 64'(busy), 64'd0);
        chk("late_done_data", out_data, 64'd0);
        chk("late_done_ready", 64'(in_ready), 64'd1);
        run_vec({16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}, 2'd1, 2, 1'b0);

        // single-lane instance, second vector held valid behind the first
        av[0] = 16'h1234; opv[0] = 2'd1;
        av[1] = 16'h4321; opv[1] = 2'd2;
        in_valid1 = 1'b1;
        in_data1 = av[0];
        in_op1 = opv[0];
        @(negedge CLK);
        chk("u1_busy", 64'(busy1), 64'd1);
        chk("u1_not_ready", 64'(in_ready1), 64'd0);
        in_data1 = av[1];
        in_op1 = opv[1];
        for (int v = 0; v < 2; v++) begin
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (exp_valid_in1) begin
                    got = 1'b1;
                    break;
                end
                @(negedge CLK);
            end
            chk("u1_issue", 64'(got), 64'd1);
            chk("u1_exp_a", 64'(exp_a1), 64'(av[v]));
            if (v == 1) in_valid1 = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            md1 = 1'b1;
            r1 = fexp(av[v], opv[v]);
            @(negedge CLK);
            md1 = 1'b0;
            chk("u1_out_valid", 64'(out_valid1), 64'd1);
            chk("u1_out_data", 64'(out_data1), 64'(fexp(av[v], opv[v])));
            chk("u1_hold_ready", 64'(in_ready1), 64'd0);
            @(negedge CLK);
            chk("u1_stall_data", 64'(out_data1), 64'(fexp(av[v], opv[v])));
            out_ready1 = 1'b1;
            chk("u1_hs_ready", 64'(in_ready1), 64'd0);
            @(negedge CLK);
            out_ready1 = 1'b0;
            chk("u1_post_hs_valid", 64'(out_valid1), 64'd0);
            chk("u1_post_hs_ready", 64'(in_ready1), 64'd1);
            if (v == 0) @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vexp_lane_seq.md
VEXP_LANE_SEQ -- requirements
Module: vexp_lane_seq

Interface
REQ-001 Parameter: LANES, default 4, number of bf16 lanes per vector (LANES >= 1).
REQ-002 Parameter: OP_W, default 2, width of the exp-unit operand/opcode field.
REQ-003 Port: CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: nRST  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  upstream vector valid.
REQ-006 Port: in_ready  output  1  sequencer can accept a vector.
REQ-007 Port: in_data  input  LANES*16  bf16 lanes; lane i is bits [16i+15:16i].
REQ-008 Port: in_op  input  OP_W  operand/opcode for the whole vector.
REQ-009 Port: exp_valid_in  output  1  single-cycle issue strobe to the exp unit.
REQ-010 Port: exp_operand  output  OP_W  opcode forwarded to the exp unit.
REQ-011 Port: exp_a  output  16  bf16 lane value forwarded to the exp unit.
REQ-012 Port: exp_done  input  1  exp unit result-valid pulse.
REQ-013 Port: exp_result  input  16  bf16 result, sampled when exp_done=1.
REQ-014 Port: out_valid  output  1  result vector valid.
REQ-015 Port: out_ready  input  1  downstream can accept the result vector.
REQ-016 Port: out_data  output  LANES*16  result lanes, in the same lane order as in_data.
REQ-017 Port: busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 Accept condition: in_valid & in_ready; on accept, latch in_data and in_op, clear lane index to 0, go to ISSUE.
REQ-021 ISSUE: assert exp_valid_in for exactly one cycle with exp_a = latched lane[idx] and exp_operand = latched op; go to WAIT.
REQ-022 exp_a and exp_operand SHALL hold their values from ISSUE through the end of WAIT.
REQ-023 WAIT: on exp_done=1, write exp_result into result lane idx.
REQ-024 WAIT exit: if idx == LANES-1, go to DONE; otherwise increment idx and go to ISSUE.
REQ-025 exp_done is ignored outside WAIT; a result is never captured twice.
REQ-026 At most one operation is outstanding at the exp unit at any time.
REQ-027 Per-lane latency: 1 ISSUE cycle + exp-unit latency + 1 capture cycle. out_valid rises on the cycle after the last capture.
REQ-028 DONE: out_valid=1 and out_data is stable until out_ready=1; the handshake cycle returns the FSM to IDLE.
REQ-029 Back-to-back: a new vector SHALL NOT be accepted in the same cycle the output handshake completes (in_ready rises the next cycle).
REQ-030 Lane index counter is ceil(log2(LANES)) bits wide (minimum 1) and never exceeds LANES-1.

Reset
REQ-031 On nRST=0, regardless of state, all of the following clear immediately: state=IDLE, idx=0, exp_valid_in=0, out_valid=0, busy=0, out_data=0, exp_a=0, exp_operand=0, latched input=0.
REQ-032 Reset mid-operation abandons the vector; a late exp_done after reset release is ignored (state is IDLE).

Configuration
REQ-033 Macro VEXP_SEQ_ZERO_BYPASS_EN, when defined: in ISSUE, a lane with bits[14:0]==0 (+0 or -0) SHALL NOT be issued. Instead, 0x3F80 (bf16 1.0) is written to that lane in the same cycle, and the FSM advances as in REQ-024, skipping WAIT.
REQ-034 When VEXP_SEQ_ZERO_BYPASS_EN is undefined, every lane is issued to the exp unit; no bypass logic is present.

Verification (exp-unit model: fixed 3-cycle latency, exp_done one cycle wide)
REQ-035 Single vector: in_data lanes {0x3F80,0x3F80,0x3F80,0x3F80}, model returns 0x402E -> exactly 4 exp_valid_in pulses, out_data all lanes 0x402E, out_valid on the cycle after the 4th exp_done.
REQ-036 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, busy=1 throughout; out_ready=1 -> IDLE the next cycle, in_ready=1 the cycle after the handshake.
REQ-037 Spurious done: exp_done pulsed in IDLE and in ISSUE -> no lane written, no state change.
REQ-038 Reset mid-WAIT on lane 2 -> out_valid=0 and exp_valid_in=0 immediately; a following exp_done is ignored; the next vector completes correctly.
REQ-039 Zero lanes {0x0000,0x3F80,0x8000,0x3F80}: with VEXP_SEQ_ZERO_BYPASS_EN -> 2 issues, lanes 0 and 2 = 0x3F80; without the macro -> 4 issues.
REQ-040 LANES=1, two vectors presented back-to-back -> each vector completes, and the second is accepted only after the first's output handshake.
